uart_rx_module: RTL and testbench



---
 rtl/uart_rx_module.sv | 133 +++++++++++++
 tb/tb_uart_rx_module.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_module.sv
// UART 8N1 receiver driven by the shared 16x baud tick; samples each bit at its
// middle, shifts LSB first, and strobes RXDONE/FERR for one cycle at mid stop bit.
module uart_rx_module #(
    parameter int NB_RXMODULE_DATA  = 8,
    parameter int SB_RXMODULE_TICKS = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_rxmodule_RX,
    input  logic                        i_rxmodule_BRGTICKS,
    output logic [NB_RXMODULE_DATA-1:0] o_rxmodule_DOUT,
    output logic                        o_rxmodule_RXDONE,
    output logic                        o_rxmodule_FERR,
    output logic                        o_rxmodule_BUSY
);

    localparam int BCW = (NB_RXMODULE_DATA > 1) ? $clog2(NB_RXMODULE_DATA) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    state_t                      state, state_next;
    logic [4:0]                  tick_cnt, tick_cnt_next;
    logic [BCW-1:0]              bit_cnt, bit_cnt_next;
    logic [NB_RXMODULE_DATA-1:0] shreg, shreg_next;
    logic [NB_RXMODULE_DATA-1:0] dout, dout_next;
    logic                        done, done_next;
    logic                        ferr, ferr_next;
    logic                        rx_meta, rx_s, rx_prev;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rxmodule_RX;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            dout     <= '0;
            done     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_cnt_next;
            bit_cnt  <= bit_cnt_next;
            shreg    <= shreg_next;
            dout     <= dout_next;
            done     <= done_next;
            ferr     <= ferr_next;
        end
    end

    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        bit_cnt_next  = bit_cnt;
        shreg_next    = shreg;
        dout_next     = dout;
        done_next     = 1'b0;
        ferr_next     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_next    = START;
                    tick_cnt_next = '0;
                end
            end
            START: begin
                if (i_rxmodule_BRGTICKS) begin
                    if (tick_cnt == 5'd7) begin
                        if (!rx_s) begin
                            state_next    = DATA;
                            tick_cnt_next = '0;
                            bit_cnt_next  = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt + 5'd1;
                    end
                end
            end
            DATA: begin
                if (i_rxmodule_BRGTICKS) begin
                    if (tick_cnt == 5'd15) begin
                        tick_cnt_next = '0;
                        shreg_next    = {rx_s, shreg[NB_RXMODULE_DATA-1:1]};
                        if (bit_cnt == BCW'(NB_RXMODULE_DATA - 1))
                            state_next = STOP;
                        else
                            bit_cnt_next = bit_cnt + 1'b1;
                    end else begin
                        tick_cnt_next = tick_cnt + 5'd1;
                    end
                end
            end
            STOP: begin
                if (i_rxmodule_BRGTICKS) begin
                    if (tick_cnt == 5'(SB_RXMODULE_TICKS - 1)) begin
                        state_next = IDLE;
                        dout_next  = shreg;
                        done_next  = 1'b1;
                        ferr_next  = ~rx_s;
                    end else begin
                        tick_cnt_next = tick_cnt + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_rxmodule_DOUT   = dout;
    assign o_rxmodule_RXDONE = done;
    assign o_rxmodule_FERR   = ferr;
    assign o_rxmodule_BUSY   = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_module.sv
// Directed bench for uart_rx_module: 8N1 frames at one tick per 4 clocks
// (64 clocks per bit), with glitch, break, back-to-back and mid-frame reset cases.
module tb_uart_rx_module;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       tick;
    logic [7:0] dout;
    logic       rxdone;
    logic       ferr;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned done_cnt = 0;
    int unsigned ferr_stray = 0;
    logic        busy_d = 1'b0;
    logic        busy_mid;
    logic [7:0]  q_dout[$];
    logic        q_ferr[$];
    logic        q_busy[$];

    uart_rx_module #(
        .NB_RXMODULE_DATA (8),
        .SB_RXMODULE_TICKS(16)
    ) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_rxmodule_RX      (rx),
        .i_rxmodule_BRGTICKS(tick),
        .o_rxmodule_DOUT    (dout),
        .o_rxmodule_RXDONE  (rxdone),
        .o_rxmodule_FERR    (ferr),
        .o_rxmodule_BUSY    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    // Records every done strobe with its data, flag and BUSY on the preceding cycle.
    always @(negedge clk) begin
        if (rxdone) begin
            done_cnt++;
            q_dout.push_back(dout);
            q_ferr.push_back(ferr);
            q_busy.push_back(busy_d);
        end
        if (ferr && !rxdone) ferr_stray++;
        busy_d = busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        busy_mid = busy;
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_clks(BIT_CLKS);
        end
        rx = stop_bit;
        wait_clks(BIT_CLKS);
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] exp_d, input logic exp_f);
        check({tag, "_avail"}, 32'(q_dout.size() > 0), 32'd1);
        if (q_dout.size() > 0) begin
            check({tag, "_dout"}, 32'(q_dout.pop_front()), 32'(exp_d));
            check({tag, "_ferr"}, 32'(q_ferr.pop_front()), 32'(exp_f));
            void'(q_busy.pop_front());
        end
    endtask

    initial begin
        int unsigned base;
        int unsigned busy_hi;

        reset = 1'b1;
        rx    = 1'b1;
        wait_clks(20);
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_done", 32'(rxdone), 32'd0);
        check("rst_ferr", 32'(ferr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", done_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_clks(40);

        // Basic frame
        send_frame(8'hA5, 1'b1);
        check("a5_count", done_cnt, 32'd1);
        check("a5_busy_mid", 32'(busy_mid), 32'd1);
        check("a5_busy_before_done", 32'(q_busy.size() > 0 ? q_busy[0] : 1'b0), 32'd1);
        expect_frame("a5", 8'hA5, 1'b0);
        check("a5_busy_after", 32'(busy), 32'd0);
        wait_clks(64);

        // Glitch rejection
        base = done_cnt;
        rx = 1'b0;
        wait_clks(8);
        check("glitch_busy_hi", 32'(busy), 32'd1);
        wait_clks(8);
        rx = 1'b1;
        wait_clks(100);
        check("glitch_busy_lo", 32'(busy), 32'd0);
        check("glitch_no_done", done_cnt, base);
        send_frame(8'h3C, 1'b1);
        check("g3c_count", done_cnt, base + 1);
        expect_frame("g3c", 8'h3C, 1'b0);
        wait_clks(64);

        // Framing error followed by break
        base = done_cnt;
        send_frame(8'h3C, 1'b0);
        check("ferr_count", done_cnt, base + 1);
        expect_frame("ferr", 8'h3C, 1'b1);
        busy_hi = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (busy) busy_hi++;
        end
        check("break_busy", busy_hi, 32'd0);
        check("break_no_done", done_cnt, base + 1);
        rx = 1'b1;
        wait_clks(BIT_CLKS);

        // Back-to-back frames
        base = done_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        check("b2b_count", done_cnt, base + 3);
        expect_frame("b2b0", 8'h00, 1'b0);
        expect_frame("b2b1", 8'hFF, 1'b0);
        expect_frame("b2b2", 8'h81, 1'b0);
        wait_clks(64);

        // Reset during data bit 3 of 0x55
        base = done_cnt;
        @(negedge clk);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx = i[0] ? 1'b0 : 1'b1;
            wait_clks(BIT_CLKS);
        end
        rx = 1'b0;
        wait_clks(BIT_CLKS / 2);
        check("mid_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        rx    = 1'b1;
        wait_clks(2);
        check("mid_rst_dout", 32'(dout), 32'h00);
        check("mid_rst_done", 32'(rxdone), 32'd0);
        check("mid_rst_ferr", 32'(ferr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        wait_clks(3);
        reset = 1'b0;
        wait_clks(2 * BIT_CLKS);
        check("mid_no_done", done_cnt, base);
        check("mid_busy_idle", 32'(busy), 32'd0);
        send_frame(8'hC3, 1'b1);
        check("c3_count", done_cnt, base + 1);
        expect_frame("c3", 8'hC3, 1'b0);
        wait_clks(64);

        check("ferr_stray", ferr_stray, 32'd0);
        check("queue_empty", 32'(q_dout.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
